mux8_way16: RTL and testbench
=============================

Name: mux8_way16

Overview:
- Registered 8-input, 16-bit-wide multiplexer in the elementary-logic-gate library of the small computer.
- A 3-bit select S picks one of eight data words A..H.
- The selected word is captured into the output register Y on the next rising clock edge.
- Used wherever the datapath selects among eight same-width sources, such as register-file read ports and ALU operand sources.

Parameters:
- WIDTH, 16, bit width of every data input and of Y. The bench uses 16 only; other values need not be verified.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- S  input  3  select code.
- A  input  WIDTH  data word selected by S=3'b000.
- B  input  WIDTH  data word selected by S=3'b001.
- C  input  WIDTH  data word selected by S=3'b010.
- D  input  WIDTH  data word selected by S=3'b011.
- E  input  WIDTH  data word selected by S=3'b100.
- F  input  WIDTH  data word selected by S=3'b101.
- G  input  WIDTH  data word selected by S=3'b110.
- H  input  WIDTH  data word selected by S=3'b111.
- Y  output  WIDTH  registered selected word.

Behaviour:
- Selection function, pure combinational: sel = {A,B,C,D,E,F,G,H}[S], with A at index 0 and H at index 7.
- Every one of the eight S codes is defined; there is no default or invalid code.
- Structure: binary tree of 2-way WIDTH-bit muxes.
  - S[0] chooses within the pairs (A,B), (C,D), (E,F), (G,H).
  - S[1] chooses within the pairs of those results.
  - S[2] makes the final choice.
  - The result must equal the flat index selection bit-for-bit.
- Register: on each rising edge of clk:
  - if rst_n==0, Y <= 0 (all WIDTH bits);
  - otherwise Y <= sel.
- Reset value: Y = 0. Y is undefined only before the first clock edge.
- Latency: exactly 1 cycle. A change on S or on any data input appears on Y after the next rising edge, never combinationally.
- Throughput: one new selection per cycle. There is no handshake, enable or stall.
- Reset mid-operation: a cycle with rst_n low forces Y to 0 regardless of S and the data inputs. The first edge with rst_n high reloads Y with the current sel.
- Reset has priority over data: if rst_n is low and inputs change on the same edge, Y is 0.
- Data inputs that are not selected have no effect on Y.
- Inputs may change every cycle; only values present at the rising edge matter.
- The output carries no X-propagation requirement beyond standard simulator semantics.

Decomposition:
- Shared package: the constant WIDTH_DEFAULT = 16, and named select codes SEL_A..SEL_H = 3'd0..3'd7 for use by benches and instantiating blocks.
- One sub-module is natural: mux2_way16, a combinational WIDTH-bit 2:1 mux with ports Y, S, A, B where S=0 selects A.
  - Seven instances form the tree: four on S[0], two on S[1], one on S[2].
  - The top level adds only the output register and reset.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with S=3'b101 and all inputs nonzero -> Y=16'h0000 after each edge. Release rst_n -> after the next edge Y=16'h0A00 (F).
- Full sweep: A=F000, B=0F00, C=00F0, D=000F, E=A000, F=0A00, G=00A0, H=000A; step S 000..111 one per cycle. Each Y, one cycle after its S value, must read F000, 0F00, 00F0, 000F, A000, 0A00, 00A0, 000A in order.
- Latency check: change S from 000 to 011 mid-cycle -> Y stays F000 until the next rising edge, then becomes 000F. No combinational glitch on Y.
- Isolation: S=3'b010 with C=1234 fixed; toggle A,B,D,E,F,G,H between 0000 and FFFF each cycle -> Y stays 1234.
- Reset mid-stream: during the sweep, drop rst_n for one cycle at S=3'b110 -> Y=0000 for that edge. The next edge, with S=3'b111, gives Y=000A.
- Randomised: 1000 cycles of random S, random data and about 5% random rst_n low; compare against a reference model Y(t+1) = rst_n ? sel(t) : 0 -> zero mismatches.

Source files
------------

// File: rtl/mux8_way16_pkg.sv
// Shared constants for the 8-way word multiplexer: default data width and
// the named select codes used by instantiating blocks and benches.
package mux8_way16_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;

    // Select codes; A is index 0, H is index 7. All eight codes are valid.
    typedef enum logic [2:0] {
        SEL_A = 3'd0,
        SEL_B = 3'd1,
        SEL_C = 3'd2,
        SEL_D = 3'd3,
        SEL_E = 3'd4,
        SEL_F = 3'd5,
        SEL_G = 3'd6,
        SEL_H = 3'd7
    } sel_e;

endpackage

// File: rtl/mux8_way16_if.sv
// Bus bundle for the 8-way multiplexer: select code, eight data words and
// the registered result.
interface mux8_way16_if #(
    parameter int unsigned WIDTH = mux8_way16_pkg::WIDTH_DEFAULT
);
    logic [2:0]       S;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] E;
    logic [WIDTH-1:0] F;
    logic [WIDTH-1:0] G;
    logic [WIDTH-1:0] H;
    logic [WIDTH-1:0] Y;

    // Source of select and data, consumer of the result.
    modport master (
        output S, A, B, C, D, E, F, G, H,
        input  Y
    );

    // The multiplexer itself.
    modport slave (
        input  S, A, B, C, D, E, F, G, H,
        output Y
    );
endinterface

// File: rtl/mux8_way16_mux2.sv
// Combinational WIDTH-bit 2:1 multiplexer; S=0 selects A, S=1 selects B.
module mux2_way16 #(
    parameter int unsigned WIDTH = mux8_way16_pkg::WIDTH_DEFAULT
) (
    output logic [WIDTH-1:0] Y,
    input  logic             S,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B
);

    assign Y = S ? B : A;

endmodule

// File: rtl/mux8_way16.sv
// Registered 8-way WIDTH-bit multiplexer. A binary tree of 2:1 muxes forms
// the selected word (S[0] at the leaves, S[2] at the root); the result is
// captured into Y on each rising edge, cleared by synchronous active-low reset.
module mux8_way16
    import mux8_way16_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    mux8_way16_if.slave  bus
);

    logic [WIDTH-1:0] ab;
    logic [WIDTH-1:0] cd;
    logic [WIDTH-1:0] ef;
    logic [WIDTH-1:0] gh;
    logic [WIDTH-1:0] abcd;
    logic [WIDTH-1:0] efgh;
    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;

    // First level: S[0] picks within each adjacent pair.
    mux2_way16 #(.WIDTH(WIDTH)) u_ab (.Y(ab), .S(bus.S[0]), .A(bus.A), .B(bus.B));
    mux2_way16 #(.WIDTH(WIDTH)) u_cd (.Y(cd), .S(bus.S[0]), .A(bus.C), .B(bus.D));
    mux2_way16 #(.WIDTH(WIDTH)) u_ef (.Y(ef), .S(bus.S[0]), .A(bus.E), .B(bus.F));
    mux2_way16 #(.WIDTH(WIDTH)) u_gh (.Y(gh), .S(bus.S[0]), .A(bus.G), .B(bus.H));

    // Second level: S[1] picks between pair results.
    mux2_way16 #(.WIDTH(WIDTH)) u_abcd (.Y(abcd), .S(bus.S[1]), .A(ab), .B(cd));
    mux2_way16 #(.WIDTH(WIDTH)) u_efgh (.Y(efgh), .S(bus.S[1]), .A(ef), .B(gh));

    // Root: S[2] makes the final choice.
    mux2_way16 #(.WIDTH(WIDTH)) u_root (.Y(sel), .S(bus.S[2]), .A(abcd), .B(efgh));

    // Next-state value of the output register is the tree result.
    always_comb begin
        y_d = sel;
    end

    // Output register; reset takes priority over the selected data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign bus.Y = y_q;

endmodule

// File: tb/tb_mux8_way16.sv
// Self-checking bench for mux8_way16: directed reset, sweep, latency,
// isolation and mid-stream reset scenarios, then randomized traffic checked
// against an array-indexing reference model.
module tb_mux8_way16;
    import mux8_way16_pkg::*;

    localparam int unsigned W = 16;

    logic clk;
    logic rst_n;

    int total;
    int bad;

    // Data words indexed by select code (A=0 .. H=7).
    logic [W-1:0] d [8];

    mux8_way16_if #(.WIDTH(W)) bus ();

    mux8_way16 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Copy the data array and select onto the bus.
    task automatic drive(input logic [2:0] s);
        bus.S = s;
        bus.A = d[0];
        bus.B = d[1];
        bus.C = d[2];
        bus.D = d[3];
        bus.E = d[4];
        bus.F = d[5];
        bus.G = d[6];
        bus.H = d[7];
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_sweep_data();
        d[0] = 16'hF000; d[1] = 16'h0F00; d[2] = 16'h00F0; d[3] = 16'h000F;
        d[4] = 16'hA000; d[5] = 16'h0A00; d[6] = 16'h00A0; d[7] = 16'h000A;
    endtask

    task automatic test_reset();
        logic [W-1:0] exp_vals [8];
        load_sweep_data();
        rst_n = 1'b0;
        drive(3'b101);
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (bus.Y !== 16'h0000) begin
                bad++;
                $display("FAIL reset_hold[%0d]: Y=%h expected=%h", i, bus.Y, 16'h0000);
            end
        end
        rst_n = 1'b1;
        step();
        total++;
        if (bus.Y !== 16'h0A00) begin
            bad++;
            $display("FAIL reset_release: Y=%h expected=%h", bus.Y, 16'h0A00);
        end
        exp_vals = d;
    endtask

    task automatic test_sweep();
        logic [W-1:0] expect_seq [8];
        expect_seq = '{16'hF000, 16'h0F00, 16'h00F0, 16'h000F,
                       16'hA000, 16'h0A00, 16'h00A0, 16'h000A};
        load_sweep_data();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(3'(i));
            step();
            total++;
            if (bus.Y !== expect_seq[i]) begin
                bad++;
                $display("FAIL sweep S=%0d: Y=%h expected=%h", i, bus.Y, expect_seq[i]);
            end
        end
    endtask

    task automatic test_latency();
        load_sweep_data();
        rst_n = 1'b1;
        drive(SEL_A);
        step();
        total++;
        if (bus.Y !== 16'hF000) begin
            bad++;
            $display("FAIL latency_setup: Y=%h expected=%h", bus.Y, 16'hF000);
        end
        #2;
        drive(SEL_D);
        for (int t = 0; t < 3; t++) begin
            #1;
            total++;
            if (bus.Y !== 16'hF000) begin
                bad++;
                $display("FAIL latency_hold[%0d]: Y=%h expected=%h", t, bus.Y, 16'hF000);
            end
        end
        step();
        total++;
        if (bus.Y !== 16'h000F) begin
            bad++;
            $display("FAIL latency_update: Y=%h expected=%h", bus.Y, 16'h000F);
        end
    endtask

    task automatic test_isolation();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 8; k++) d[k] = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
            d[2] = 16'h1234;
            drive(SEL_C);
            step();
            total++;
            if (bus.Y !== 16'h1234) begin
                bad++;
                $display("FAIL isolation[%0d]: Y=%h expected=%h", i, bus.Y, 16'h1234);
            end
        end
    endtask

    task automatic test_reset_midstream();
        load_sweep_data();
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] e;
            rst_n = (i == 6) ? 1'b0 : 1'b1;
            drive(3'(i));
            e = rst_n ? d[i] : '0;
            step();
            total++;
            if (bus.Y !== e) begin
                bad++;
                $display("FAIL midreset S=%0d: Y=%h expected=%h", i, bus.Y, e);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 1000; n++) begin
            logic [2:0]   s;
            logic [W-1:0] e;
            for (int k = 0; k < 8; k++) d[k] = W'($urandom);
            s = 3'($urandom_range(0, 7));
            rst_n = ($urandom_range(0, 99) < 5) ? 1'b0 : 1'b1;
            drive(s);
            e = rst_n ? d[s] : '0;
            step();
            total++;
            if (bus.Y !== e) begin
                bad++;
                $display("FAIL random[%0d] S=%0d rst_n=%b: Y=%h expected=%h",
                         n, s, rst_n, bus.Y, e);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        for (int k = 0; k < 8; k++) d[k] = '0;
        drive(3'b000);
        #1;
        test_reset();
        test_sweep();
        test_latency();
        test_isolation();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
